// File: rtl/wifi_tx_pkg.sv
// wifi_tx_pkg: state encodings, field widths, RATE codes and data-bits-per-symbol lookup for the PLCP framer
package wifi_tx_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_PRE     = 4'd1;
  localparam state_t S_RATE    = 4'd2;
  localparam state_t S_RSVD    = 4'd3;
  localparam state_t S_LEN     = 4'd4;
  localparam state_t S_PAR     = 4'd5;
  localparam state_t S_SIGTAIL = 4'd6;
  localparam state_t S_SERV    = 4'd7;
  localparam state_t S_PSDU    = 4'd8;
  localparam state_t S_TAIL    = 4'd9;
  localparam state_t S_PAD     = 4'd10;
  localparam state_t S_DONE    = 4'd11;
  localparam int W_RATE    = 4;
  localparam int W_RSVD    = 1;
  localparam int W_LEN     = 12;
  localparam int W_PAR     = 1;
  localparam int W_SIGTAIL = 6;
  localparam int W_SERV    = 16;
  localparam int W_TAIL    = 6;
  localparam logic [0:3] RATE_6  = 4'b1101;
  localparam logic [0:3] RATE_9  = 4'b1111;
  localparam logic [0:3] RATE_12 = 4'b0101;
  localparam logic [0:3] RATE_18 = 4'b0111;
  localparam logic [0:3] RATE_24 = 4'b1001;
  localparam logic [0:3] RATE_36 = 4'b1011;
  localparam logic [0:3] RATE_48 = 4'b0001;
  localparam logic [0:3] RATE_54 = 4'b0011;
  localparam logic [7:1] DEFAULT_SEED = 7'h7F;
  function automatic logic [7:0] n_dbps(input logic [0:3] rate);
    case (rate)
      RATE_9:  return 8'd36;
      RATE_12: return 8'd48;
      RATE_18: return 8'd72;
      RATE_24: return 8'd96;
      RATE_36: return 8'd144;
      RATE_48: return 8'd192;
      RATE_54: return 8'd216;
      default: return 8'd24;
    endcase
  endfunction
endpackage

// File: rtl/frame_scrambler.sv
// frame_scrambler: x^7+x^4+1 additive scrambler; Out is the combinational scrambled version of In
module frame_scrambler (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:1] Seed,
  input  logic       Enable,
  input  logic       In,
  output logic       Out
);
  logic [7:1] s;
  logic fb;
  assign fb  = s[7] ^ s[4];
  assign Out = In ^ fb;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) s <= '0;
    else if (Load) s <= Seed;
    else if (Enable) s <= {s[6:1], fb};
endmodule

// File: rtl/plcp_frame_tx.sv
// plcp_frame_tx: 802.11a PLCP transmit framer/serialiser (preamble, SIGNAL, scrambled DATA)
// Define PAD_BITS_EN to pad the DATA field to a whole number of OFDM symbols.
module plcp_frame_tx
  import wifi_tx_pkg::*;
#(
  parameter int         PREAMBLE_BITS = 96,
  parameter logic [7:0] PREAMBLE_BYTE = 8'hAA
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [0:3]  Rate,
  input  logic [0:11] Length,
  input  logic [7:1]  Init,
  input  logic [7:0]  PsduData,
  input  logic        PsduValid,
  output logic        PsduReady,
  output logic        Output,
  output logic        OutValid,
  output logic        Busy,
  output logic        Done
);
  state_t state, nxt, tail_nxt;
  logic [14:0] cnt, flen;
  logic [0:3] rate_q;
  logic [0:11] len_q;
  logic [7:1] seed_q;
  logic hold_full;
  logic [7:0] hold, shift;
  logic [11:0] req;
  logic boundary, stall, emit, scr_en, last, adv, d, scr_out;
  assign boundary  = state == S_PSDU && cnt[2:0] == 3'd0;
  assign stall     = boundary && !hold_full;
  assign emit      = state >= S_PRE && state <= S_PAD && !stall;
  assign scr_en    = emit && (state == S_SERV || state == S_PSDU || state == S_PAD);
  assign last      = cnt == flen - 15'd1;
  assign PsduReady = (state == S_SERV || state == S_PSDU) && !hold_full && req < len_q;
  assign nxt = state == S_SERV && len_q == 12'd0 ? S_TAIL : state == S_TAIL ? tail_nxt : state + 4'd1;
  always_comb begin
    flen = 15'd1;
    case (state)
      S_PRE:     flen = 15'(PREAMBLE_BITS);
      S_RATE:    flen = 15'(W_RATE);
      S_RSVD:    flen = 15'(W_RSVD);
      S_LEN:     flen = 15'(W_LEN);
      S_PAR:     flen = 15'(W_PAR);
      S_SIGTAIL: flen = 15'(W_SIGTAIL);
      S_SERV:    flen = 15'(W_SERV);
      S_PSDU:    flen = {len_q, 3'b000};
      S_TAIL:    flen = 15'(W_TAIL);
      default:   flen = 15'd1;
    endcase
  end
  always_comb begin
    d = 1'b0;
    case (state)
      S_PRE:  d = PREAMBLE_BYTE[~cnt[2:0]];
      S_RATE: d = rate_q[cnt[1:0]];
      S_LEN:  d = len_q[cnt[3:0]];
      S_PAR:  d = ^{rate_q, len_q};
      S_PSDU: d = boundary ? hold[0] : shift[0];
      default: d = 1'b0;
    endcase
  end
`ifdef PAD_BITS_EN
  logic [7:0] sym, sym_nxt, ndbps;
  assign ndbps    = n_dbps(rate_q);
  assign sym_nxt  = sym == ndbps - 8'd1 ? 8'd0 : sym + 8'd1;
  assign adv      = state == S_PAD ? sym_nxt == 8'd0 : last;
  assign tail_nxt = sym_nxt == 8'd0 ? S_DONE : S_PAD;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) sym <= '0;
    else if (state == S_IDLE) sym <= '0;
    else if (emit && state >= S_SERV) sym <= sym_nxt;
`else
  assign adv      = last;
  assign tail_nxt = S_DONE;
`endif
  frame_scrambler u_scr (
    .Clock  (Clock),
    .Reset  (Reset),
    .Load   (emit && state == S_SIGTAIL && last),
    .Seed   (seed_q),
    .Enable (scr_en),
    .In     (d),
    .Out    (scr_out)
  );
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rate_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      hold_full <= 1'b0;
      hold      <= '0;
      shift     <= '0;
      req       <= '0;
      Output    <= 1'b0;
      OutValid  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      OutValid <= emit;
      Output   <= emit && (scr_en ? scr_out : d);
      Done     <= state == S_DONE;
      if (state == S_IDLE && Start) begin
        Busy   <= 1'b1;
        state  <= S_PRE;
        cnt    <= '0;
        rate_q <= Rate;
        len_q  <= Length;
        seed_q <= Init == 7'd0 ? DEFAULT_SEED : Init;
        req    <= '0;
      end
      if (state == S_DONE) begin
        Busy  <= 1'b0;
        state <= S_IDLE;
      end
      if (emit) begin
        if (adv) begin
          state <= nxt;
          cnt   <= '0;
        end else cnt <= cnt + 15'd1;
      end
      if (emit && state == S_PSDU) shift <= boundary ? hold >> 1 : shift >> 1;
      // ready implies an empty hold, so a fill and a drain never coincide
      if (PsduValid && PsduReady) begin
        hold      <= PsduData;
        hold_full <= 1'b1;
        req       <= req + 12'd1;
      end else if (emit && boundary) hold_full <= 1'b0;
    end
endmodule
